// File: rtl/control_pipe_unit.sv
// control_pipe_unit
//   Main-decoder control path for a 5-stage MIPS-like pipeline. The opcode is
//   decoded combinationally in D. The controls then travel through the E, M
//   and W pipeline registers. A saturating counter records illegal opcodes
//   that were actually issued.
//
// Parameters
//   Opcode_width  opcode field width (decode constants are 6-bit MIPS codes)
//   ALU_OP_width  ALUOp width, must be >= 3
//   EXT_ISA       1 enables bne/andi/ori/slti; 0 decodes them as illegal
//   CNT_width     illegal-opcode counter width
//
// Ports
//   CLK, RST                 clock, asynchronous active-low reset
//   Opcode, Stall_D, Flush_E decode opcode, decode hold, execute bubble request
//   Jump_D .. Illegal_D      combinational decode-stage flags
//   *_E, ALUOp_E             execute-stage controls
//   *_M, *_W                 memory / writeback-stage controls
//   Illegal_Count            saturating count of issued illegal opcodes
module control_pipe_unit #(
  parameter int Opcode_width = 6,
  parameter int ALU_OP_width = 3,
  parameter int EXT_ISA      = 1,
  parameter int CNT_width    = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [Opcode_width-1:0] Opcode,
  input  logic                    Stall_D,
  input  logic                    Flush_E,
  output logic                    Jump_D,
  output logic                    Branch_D,
  output logic                    BranchNE_D,
  output logic                    Illegal_D,
  output logic                    RegWrite_E,
  output logic                    MemtoReg_E,
  output logic                    MemWrite_E,
  output logic                    ALUSrc_E,
  output logic                    RegDst_E,
  output logic                    ZeroExt_E,
  output logic [ALU_OP_width-1:0] ALUOp_E,
  output logic                    RegWrite_M,
  output logic                    MemtoReg_M,
  output logic                    MemWrite_M,
  output logic                    RegWrite_W,
  output logic                    MemtoReg_W,
  output logic [CNT_width-1:0]    Illegal_Count
);

  localparam logic [Opcode_width-1:0] OP_RTYPE = Opcode_width'(6'b000000);
  localparam logic [Opcode_width-1:0] OP_J     = Opcode_width'(6'b000010);
  localparam logic [Opcode_width-1:0] OP_BEQ   = Opcode_width'(6'b000100);
  localparam logic [Opcode_width-1:0] OP_BNE   = Opcode_width'(6'b000101);
  localparam logic [Opcode_width-1:0] OP_ADDI  = Opcode_width'(6'b001000);
  localparam logic [Opcode_width-1:0] OP_SLTI  = Opcode_width'(6'b001010);
  localparam logic [Opcode_width-1:0] OP_ANDI  = Opcode_width'(6'b001100);
  localparam logic [Opcode_width-1:0] OP_ORI   = Opcode_width'(6'b001101);
  localparam logic [Opcode_width-1:0] OP_LW    = Opcode_width'(6'b100011);
  localparam logic [Opcode_width-1:0] OP_SW    = Opcode_width'(6'b101011);
  localparam logic [CNT_width-1:0]    CNT_MAX  = {CNT_width{1'b1}};
  localparam bit                      EXT_ON   = (EXT_ISA != 0);

  logic                    dec_regwrite, dec_regdst, dec_alusrc, dec_memwrite;
  logic                    dec_memtoreg, dec_zeroext;
  logic [ALU_OP_width-1:0] dec_aluop;
  logic                    issue;

  logic                    regwrite_e_d, memtoreg_e_d, memwrite_e_d;
  logic                    alusrc_e_d, regdst_e_d, zeroext_e_d;
  logic [ALU_OP_width-1:0] aluop_e_d;
  logic                    regwrite_e_q, memtoreg_e_q, memwrite_e_q;
  logic                    alusrc_e_q, regdst_e_q, zeroext_e_q;
  logic [ALU_OP_width-1:0] aluop_e_q;
  logic                    regwrite_m_q, memtoreg_m_q, memwrite_m_q;
  logic                    regwrite_w_q, memtoreg_w_q;
  logic [CNT_width-1:0]    cnt_d, cnt_q;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_regdst   = 1'b0;
    dec_alusrc   = 1'b0;
    dec_memwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_zeroext  = 1'b0;
    dec_aluop    = '0;
    Branch_D     = 1'b0;
    BranchNE_D   = 1'b0;
    Jump_D       = 1'b0;
    Illegal_D    = 1'b0;
    case (Opcode)
      OP_LW: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
      end
      OP_SW: begin
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OP_RTYPE: begin
        dec_regwrite = 1'b1;
        dec_regdst   = 1'b1;
        dec_aluop    = ALU_OP_width'(3'b010);
      end
      OP_ADDI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
      end
      OP_BEQ: begin
        dec_aluop = ALU_OP_width'(3'b001);
        Branch_D  = 1'b1;
      end
      OP_J: Jump_D = 1'b1;
      // Extended opcodes fall back to illegal when the extension is disabled.
      OP_BNE: begin
        if (EXT_ON) begin
          dec_aluop  = ALU_OP_width'(3'b001);
          BranchNE_D = 1'b1;
        end else begin
          Illegal_D = 1'b1;
        end
      end
      OP_ANDI, OP_ORI: begin
        if (EXT_ON) begin
          dec_regwrite = 1'b1;
          dec_alusrc   = 1'b1;
          dec_zeroext  = 1'b1;
          dec_aluop    = (Opcode == OP_ANDI) ? ALU_OP_width'(3'b011)
                                             : ALU_OP_width'(3'b100);
        end else begin
          Illegal_D = 1'b1;
        end
      end
      OP_SLTI: begin
        if (EXT_ON) begin
          dec_regwrite = 1'b1;
          dec_alusrc   = 1'b1;
          dec_aluop    = ALU_OP_width'(3'b101);
        end else begin
          Illegal_D = 1'b1;
        end
      end
      default: Illegal_D = 1'b1;
    endcase
  end

  // A held instruction is re-presented next cycle, so it enters E as a bubble
  // now; a flush always wins. Only an issued illegal opcode is counted.
  assign issue = !Stall_D && !Flush_E;

  always_comb begin
    regwrite_e_d = issue & dec_regwrite;
    memtoreg_e_d = issue & dec_memtoreg;
    memwrite_e_d = issue & dec_memwrite;
    alusrc_e_d   = issue & dec_alusrc;
    regdst_e_d   = issue & dec_regdst;
    zeroext_e_d  = issue & dec_zeroext;
    aluop_e_d    = issue ? dec_aluop : '0;
    cnt_d        = cnt_q;
    if (issue && Illegal_D && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_width'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
      memwrite_e_q <= 1'b0;
      alusrc_e_q   <= 1'b0;
      regdst_e_q   <= 1'b0;
      zeroext_e_q  <= 1'b0;
      aluop_e_q    <= '0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      regwrite_e_q <= regwrite_e_d;
      memtoreg_e_q <= memtoreg_e_d;
      memwrite_e_q <= memwrite_e_d;
      alusrc_e_q   <= alusrc_e_d;
      regdst_e_q   <= regdst_e_d;
      zeroext_e_q  <= zeroext_e_d;
      aluop_e_q    <= aluop_e_d;
      regwrite_m_q <= regwrite_e_q;
      memtoreg_m_q <= memtoreg_e_q;
      memwrite_m_q <= memwrite_e_q;
      regwrite_w_q <= regwrite_m_q;
      memtoreg_w_q <= memtoreg_m_q;
      cnt_q        <= cnt_d;
    end
  end

  assign RegWrite_E    = regwrite_e_q;
  assign MemtoReg_E    = memtoreg_e_q;
  assign MemWrite_E    = memwrite_e_q;
  assign ALUSrc_E      = alusrc_e_q;
  assign RegDst_E      = regdst_e_q;
  assign ZeroExt_E     = zeroext_e_q;
  assign ALUOp_E       = aluop_e_q;
  assign RegWrite_M    = regwrite_m_q;
  assign MemtoReg_M    = memtoreg_m_q;
  assign MemWrite_M    = memwrite_m_q;
  assign RegWrite_W    = regwrite_w_q;
  assign MemtoReg_W    = memtoreg_w_q;
  assign Illegal_Count = cnt_q;

endmodule

// File: tb/tb_control_pipe_unit.sv
module tb_control_pipe_unit;

  typedef struct packed {
    logic       rw, mr, mw, alusrc, rd, ze;
    logic [2:0] alu;
    logic       br, bne, j, ill;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       st;
    logic       fl;
    logic [3:0] flags_exp;  // {Jump, Branch, BranchNE, Illegal}
    logic [8:0] e_exp;      // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, ZeroExt, ALUOp}
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic       Stall_D, Flush_E;

  logic       Jump_D_a, Branch_D_a, BranchNE_D_a, Illegal_D_a;
  logic       RegWrite_E_a, MemtoReg_E_a, MemWrite_E_a, ALUSrc_E_a, RegDst_E_a, ZeroExt_E_a;
  logic [2:0] ALUOp_E_a;
  logic       RegWrite_M_a, MemtoReg_M_a, MemWrite_M_a, RegWrite_W_a, MemtoReg_W_a;
  logic [7:0] Illegal_Count_a;

  logic       Jump_D_b, Branch_D_b, BranchNE_D_b, Illegal_D_b;
  logic       RegWrite_E_b, MemtoReg_E_b, MemWrite_E_b, ALUSrc_E_b, RegDst_E_b, ZeroExt_E_b;
  logic [2:0] ALUOp_E_b;
  logic       RegWrite_M_b, MemtoReg_M_b, MemWrite_M_b, RegWrite_W_b, MemtoReg_W_b;
  logic [7:0] Illegal_Count_b;

  always #5 CLK = ~CLK;

  control_pipe_unit #(.Opcode_width(6), .ALU_OP_width(3), .EXT_ISA(1), .CNT_width(8)) u_dut_a (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Stall_D(Stall_D), .Flush_E(Flush_E),
    .Jump_D(Jump_D_a), .Branch_D(Branch_D_a), .BranchNE_D(BranchNE_D_a), .Illegal_D(Illegal_D_a),
    .RegWrite_E(RegWrite_E_a), .MemtoReg_E(MemtoReg_E_a), .MemWrite_E(MemWrite_E_a),
    .ALUSrc_E(ALUSrc_E_a), .RegDst_E(RegDst_E_a), .ZeroExt_E(ZeroExt_E_a), .ALUOp_E(ALUOp_E_a),
    .RegWrite_M(RegWrite_M_a), .MemtoReg_M(MemtoReg_M_a), .MemWrite_M(MemWrite_M_a),
    .RegWrite_W(RegWrite_W_a), .MemtoReg_W(MemtoReg_W_a), .Illegal_Count(Illegal_Count_a)
  );

  control_pipe_unit #(.Opcode_width(6), .ALU_OP_width(3), .EXT_ISA(0), .CNT_width(8)) u_dut_b (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Stall_D(Stall_D), .Flush_E(Flush_E),
    .Jump_D(Jump_D_b), .Branch_D(Branch_D_b), .BranchNE_D(BranchNE_D_b), .Illegal_D(Illegal_D_b),
    .RegWrite_E(RegWrite_E_b), .MemtoReg_E(MemtoReg_E_b), .MemWrite_E(MemWrite_E_b),
    .ALUSrc_E(ALUSrc_E_b), .RegDst_E(RegDst_E_b), .ZeroExt_E(ZeroExt_E_b), .ALUOp_E(ALUOp_E_b),
    .RegWrite_M(RegWrite_M_b), .MemtoReg_M(MemtoReg_M_b), .MemWrite_M(MemWrite_M_b),
    .RegWrite_W(RegWrite_W_b), .MemtoReg_W(MemtoReg_W_b), .Illegal_Count(Illegal_Count_b)
  );

  logic [8:0] e_a, e_b;
  logic [2:0] m_a, m_b;
  logic [1:0] w_a, w_b;
  logic [3:0] f_a, f_b;
  assign e_a = {RegWrite_E_a, MemtoReg_E_a, MemWrite_E_a, ALUSrc_E_a, RegDst_E_a, ZeroExt_E_a, ALUOp_E_a};
  assign e_b = {RegWrite_E_b, MemtoReg_E_b, MemWrite_E_b, ALUSrc_E_b, RegDst_E_b, ZeroExt_E_b, ALUOp_E_b};
  assign m_a = {RegWrite_M_a, MemtoReg_M_a, MemWrite_M_a};
  assign m_b = {RegWrite_M_b, MemtoReg_M_b, MemWrite_M_b};
  assign w_a = {RegWrite_W_a, MemtoReg_W_a};
  assign w_b = {RegWrite_W_b, MemtoReg_W_b};
  assign f_a = {Jump_D_a, Branch_D_a, BranchNE_D_a, Illegal_D_a};
  assign f_b = {Jump_D_b, Branch_D_b, BranchNE_D_b, Illegal_D_b};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic ctl_t dec(input logic [5:0] op, input bit ext);
    ctl_t c = '0;
    case (op)
      6'b100011: begin c.rw = 1; c.alusrc = 1; c.mr = 1; end
      6'b101011: begin c.alusrc = 1; c.mw = 1; end
      6'b000000: begin c.rw = 1; c.rd = 1; c.alu = 3'd2; end
      6'b001000: begin c.rw = 1; c.alusrc = 1; end
      6'b000100: begin c.alu = 3'd1; c.br = 1; end
      6'b000010: c.j = 1;
      6'b000101: if (ext) begin c.alu = 3'd1; c.bne = 1; end else c.ill = 1;
      6'b001100: if (ext) begin c.rw = 1; c.alusrc = 1; c.ze = 1; c.alu = 3'd3; end else c.ill = 1;
      6'b001101: if (ext) begin c.rw = 1; c.alusrc = 1; c.ze = 1; c.alu = 3'd4; end else c.ill = 1;
      6'b001010: if (ext) begin c.rw = 1; c.alusrc = 1; c.alu = 3'd5; end else c.ill = 1;
      default:   c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic logic [8:0] e_of(input ctl_t c);
    return {c.rw, c.mr, c.mw, c.alusrc, c.rd, c.ze, c.alu};
  endfunction

  function automatic logic [3:0] f_of(input ctl_t c);
    return {c.j, c.br, c.bne, c.ill};
  endfunction

  // Model: a history of the control words issued at each edge; the stage
  // outputs are simply the last three entries.
  ctl_t qa[$];
  ctl_t qb[$];
  int   cnt_a, cnt_b;
  ctl_t z = '0;
  ctl_t da, db;
  bit   iss;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      qa.delete(); qb.delete();
      repeat (3) begin qa.push_back(z); qb.push_back(z); end
      cnt_a = 0; cnt_b = 0;
    end else begin
      iss = !Stall_D && !Flush_E;
      da = dec(Opcode, 1'b1);
      db = dec(Opcode, 1'b0);
      qa.push_back(iss ? da : z); void'(qa.pop_front());
      qb.push_back(iss ? db : z); void'(qb.pop_front());
      if (iss && da.ill && cnt_a < 255) cnt_a++;
      if (iss && db.ill && cnt_b < 255) cnt_b++;
    end
  end

  task automatic check_model(input string tag);
    chk({tag, " flagsA"}, 16'(f_a), 16'(f_of(dec(Opcode, 1'b1))));
    chk({tag, " flagsB"}, 16'(f_b), 16'(f_of(dec(Opcode, 1'b0))));
    chk({tag, " E_A"}, 16'(e_a), 16'(e_of(qa[2])));
    chk({tag, " E_B"}, 16'(e_b), 16'(e_of(qb[2])));
    chk({tag, " M_A"}, 16'(m_a), 16'({qa[1].rw, qa[1].mr, qa[1].mw}));
    chk({tag, " M_B"}, 16'(m_b), 16'({qb[1].rw, qb[1].mr, qb[1].mw}));
    chk({tag, " W_A"}, 16'(w_a), 16'({qa[0].rw, qa[0].mr}));
    chk({tag, " W_B"}, 16'(w_b), 16'({qb[0].rw, qb[0].mr}));
    chk({tag, " cntA"}, 16'(Illegal_Count_a), 16'(cnt_a));
    chk({tag, " cntB"}, 16'(Illegal_Count_b), 16'(cnt_b));
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Called right after cyc(): reset pulse lies strictly between edges.
  task automatic do_reset();
    Stall_D = 0; Flush_E = 0;
    RST = 1'b0;
    #2;
    RST = 1'b1;
  endtask

  vec_t       tbl[14];
  logic [5:0] ops[12];

  initial begin
    tbl[0]  = '{6'b100011, 1'b0, 1'b0, 4'b0000, 9'b110100_000};
    tbl[1]  = '{6'b101011, 1'b0, 1'b0, 4'b0000, 9'b001100_000};
    tbl[2]  = '{6'b000000, 1'b0, 1'b0, 4'b0000, 9'b100010_010};
    tbl[3]  = '{6'b001000, 1'b0, 1'b0, 4'b0000, 9'b100100_000};
    tbl[4]  = '{6'b000100, 1'b0, 1'b0, 4'b0100, 9'b000000_001};
    tbl[5]  = '{6'b000010, 1'b0, 1'b0, 4'b1000, 9'b000000_000};
    tbl[6]  = '{6'b000101, 1'b0, 1'b0, 4'b0010, 9'b000000_001};
    tbl[7]  = '{6'b001100, 1'b0, 1'b0, 4'b0000, 9'b100101_011};
    tbl[8]  = '{6'b001101, 1'b0, 1'b0, 4'b0000, 9'b100101_100};
    tbl[9]  = '{6'b001010, 1'b0, 1'b0, 4'b0000, 9'b100100_101};
    tbl[10] = '{6'b111111, 1'b0, 1'b0, 4'b0001, 9'b000000_000};
    tbl[11] = '{6'b100011, 1'b1, 1'b0, 4'b0000, 9'b000000_000};
    tbl[12] = '{6'b000000, 1'b0, 1'b1, 4'b0000, 9'b000000_000};
    tbl[13] = '{6'b000100, 1'b1, 1'b1, 4'b0100, 9'b000000_000};
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010,
            6'b000101, 6'b001100, 6'b001101, 6'b001010, 6'b111111, 6'b010001};

    RST = 1'b0; Opcode = 6'b100011; Stall_D = 0; Flush_E = 0;
    repeat (2) cyc();
    chk("reset E", 16'(e_a), 16'h0);
    chk("reset M", 16'(m_a), 16'h0);
    chk("reset W", 16'(w_a), 16'h0);
    chk("reset cnt", 16'(Illegal_Count_a), 16'h0);
    RST = 1'b1;

    // Decode table, one vector per cycle.
    for (int i = 0; i < 14; i++) begin
      Opcode = tbl[i].op; Stall_D = tbl[i].st; Flush_E = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d flags", i), 16'(f_a), 16'(tbl[i].flags_exp));
      cyc();
      chk($sformatf("tbl%0d E", i), 16'(e_a), 16'(tbl[i].e_exp));
    end

    // lw, sw, R-type back to back.
    do_reset();
    Opcode = 6'b100011; cyc();
    chk("seq1 RegWrite_E c1", 16'(RegWrite_E_a), 16'd1);
    Opcode = 6'b101011; cyc();
    chk("seq1 RegWrite_E c2", 16'(RegWrite_E_a), 16'd0);
    Opcode = 6'b000000; cyc();
    chk("seq1 RegWrite_E c3", 16'(RegWrite_E_a), 16'd1);
    chk("seq1 MemWrite_M c3", 16'(MemWrite_M_a), 16'd1);
    chk("seq1 MemtoReg_W c3", 16'(MemtoReg_W_a), 16'd1);

    // andi with and without the extended ISA.
    cyc(); do_reset();
    Opcode = 6'b001100;
    #1;
    chk("andi Illegal_D ext1", 16'(Illegal_D_a), 16'd0);
    chk("andi Illegal_D ext0", 16'(Illegal_D_b), 16'd1);
    cyc();
    chk("andi ALUOp_E ext1", 16'(ALUOp_E_a), 16'd3);
    chk("andi ZeroExt_E ext1", 16'(ZeroExt_E_a), 16'd1);
    chk("andi E ext0", 16'(e_b), 16'd0);
    chk("andi cnt ext0", 16'(Illegal_Count_b), 16'd1);
    chk("andi cnt ext1", 16'(Illegal_Count_a), 16'd0);

    // addi held for two cycles, then issued exactly once.
    do_reset();
    Opcode = 6'b001000; Stall_D = 1;
    cyc(); chk("stall E c1", 16'(e_a), 16'd0);
    cyc(); chk("stall E c2", 16'(e_a), 16'd0);
    Stall_D = 0;
    cyc(); chk("stall release RW/ALUSrc", 16'({RegWrite_E_a, ALUSrc_E_a}), 16'b11);
    Opcode = 6'b000100;
    cyc(); chk("stall once RegWrite_E", 16'(RegWrite_E_a), 16'd0);

    // Stall and flush together: one bubble, nothing counted.
    do_reset();
    Opcode = 6'b000000; Stall_D = 1; Flush_E = 1;
    cyc(); chk("stflush E", 16'(e_a), 16'd0);
    Stall_D = 0; Flush_E = 0; Opcode = 6'b000100;
    cyc(); chk("stflush RegWrite_M", 16'(RegWrite_M_a), 16'd0);
    Opcode = 6'b111111; Stall_D = 1; Flush_E = 1;
    cyc(); chk("stflush no count", 16'(Illegal_Count_a), 16'd0);
    Opcode = 6'b111111; Stall_D = 1; Flush_E = 0;
    cyc(); chk("stall no count", 16'(Illegal_Count_a), 16'd0);

    // Async reset mid-pipeline, then the first edge loads E normally.
    do_reset();
    Opcode = 6'b111111; cyc();
    Opcode = 6'b100011; cyc(); cyc();
    chk("arst pre RegWrite_M", 16'(RegWrite_M_a), 16'd1);
    chk("arst pre cnt", 16'(Illegal_Count_a), 16'd1);
    #1 RST = 1'b0;
    #1;
    chk("arst RegWrite_M", 16'(RegWrite_M_a), 16'd0);
    chk("arst cnt", 16'(Illegal_Count_a), 16'd0);
    chk("arst E", 16'(e_a), 16'd0);
    RST = 1'b1;
    cyc();
    chk("arst first edge E", 16'(e_a), 16'(9'b110100_000));
    chk("arst first edge M", 16'(m_a), 16'd0);

    // Counter saturation.
    do_reset();
    Opcode = 6'b111111;
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (i == 200) chk("sat cnt 200", 16'(Illegal_Count_a), 16'd200);
    end
    chk("sat cnt 300", 16'(Illegal_Count_a), 16'd255);
    chk("sat cntB 300", 16'(Illegal_Count_b), 16'd255);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Opcode  = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 11)] : 6'($urandom);
      Stall_D = ($urandom_range(0, 3) == 0);
      Flush_E = ($urandom_range(0, 4) == 0);
      #1;
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 99) == 0) begin
        RST = 1'b0; #1; RST = 1'b1;
      end
      cyc();
    end
    check_model("rnd end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
